// File: rtl/temperature_abnormality_monitor.sv
// Multi-channel temperature band monitor: per-channel persistence filter, hysteretic
// clear, sticky alarm flags with write-1-to-clear and a registered summary interrupt.
module temperature_abnormality_monitor #(
  parameter int NUM_CH      = 4,
  parameter int TEMP_W      = 5,
  parameter int COEF_W      = 4,
  parameter int PERSIST_CNT = 3,
  parameter int CLEAR_CNT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TEMP_W-1:0]        factoryBaseTemp,
  input  logic [COEF_W-1:0]        factoryTempCoef,
  input  logic                     configLoad,
  input  logic                     sampleValid,
  input  logic [NUM_CH*TEMP_W-1:0] tempSensorValues,
  input  logic [NUM_CH-1:0]        ackMask,
  output logic [NUM_CH-1:0]        lowTempAbnormality,
  output logic [NUM_CH-1:0]        highTempAbnormality,
  output logic [NUM_CH-1:0]        stickyAlarm,
  output logic                     anyAlarm
);

  localparam int MAX_CNT = (PERSIST_CNT > CLEAR_CNT) ? PERSIST_CNT : CLEAR_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int LIM_W   = ((TEMP_W > COEF_W) ? TEMP_W : COEF_W) + 1;

  typedef enum logic [2:0] {NORMAL, PEND_LOW, PEND_HIGH, ALARM_LOW, ALARM_HIGH} chState_t;
  typedef enum logic [1:0] {IN_BAND, IS_LOW, IS_HIGH} sampleClass_t;

  // With a single-sample persistence the pending states are skipped entirely.
  localparam chState_t         ENTER_LOW  = (PERSIST_CNT == 1) ? ALARM_LOW  : PEND_LOW;
  localparam chState_t         ENTER_HIGH = (PERSIST_CNT == 1) ? ALARM_HIGH : PEND_HIGH;
  localparam logic [CNT_W-1:0] ENTER_CNT  = (PERSIST_CNT == 1) ? '0 : CNT_W'(1);
  localparam logic [CNT_W:0]   PERSIST_LIM = (CNT_W+1)'(PERSIST_CNT);
  localparam logic [CNT_W:0]   CLEAR_LIM   = (CNT_W+1)'(CLEAR_CNT);

  function automatic logic [LIM_W-1:0] satSub(input logic [LIM_W-1:0] a, input logic [LIM_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic sampleClass_t classify(input logic [LIM_W-1:0] s,
                                            input logic [LIM_W-1:0] lo,
                                            input logic [LIM_W-1:0] hi);
    if (s < lo)      return IS_LOW;
    else if (s > hi) return IS_HIGH;
    else             return IN_BAND;
  endfunction

  logic [TEMP_W-1:0] baseReg;
  logic [COEF_W-1:0] coefReg;
  logic [LIM_W-1:0]  lowLimit;
  logic [LIM_W-1:0]  highLimit;

  chState_t         state     [NUM_CH];
  chState_t         stateNext [NUM_CH];
  logic [CNT_W-1:0] cnt       [NUM_CH];
  logic [CNT_W-1:0] cntNext   [NUM_CH];
  logic [CNT_W:0]   cntInc    [NUM_CH];
  sampleClass_t     cls       [NUM_CH];
  logic [NUM_CH-1:0] enterAlarm;
  logic [NUM_CH-1:0] stickyNext;

  assign lowLimit  = satSub(LIM_W'(baseReg), LIM_W'(coefReg));
  assign highLimit = LIM_W'(baseReg) + LIM_W'(coefReg);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stateNext[i] = state[i];
      cntNext[i]   = cnt[i];
      cntInc[i]    = {1'b0, cnt[i]} + 1'b1;
      cls[i]       = classify(LIM_W'(tempSensorValues[i*TEMP_W +: TEMP_W]), lowLimit, highLimit);
      if (sampleValid) begin
        case (state[i])
          NORMAL: begin
            cntNext[i] = '0;
            if (cls[i] == IS_LOW) begin
              stateNext[i] = ENTER_LOW;  cntNext[i] = ENTER_CNT;
            end else if (cls[i] == IS_HIGH) begin
              stateNext[i] = ENTER_HIGH; cntNext[i] = ENTER_CNT;
            end
          end
          PEND_LOW, PEND_HIGH: begin
            if ((cls[i] == IS_LOW && state[i] == PEND_LOW) ||
                (cls[i] == IS_HIGH && state[i] == PEND_HIGH)) begin
              if (cntInc[i] == PERSIST_LIM) begin
                stateNext[i] = (state[i] == PEND_LOW) ? ALARM_LOW : ALARM_HIGH;
                cntNext[i]   = '0;
              end else begin
                cntNext[i] = cntInc[i][CNT_W-1:0];
              end
            end else if (cls[i] == IS_LOW) begin
              stateNext[i] = ENTER_LOW;  cntNext[i] = ENTER_CNT;
            end else if (cls[i] == IS_HIGH) begin
              stateNext[i] = ENTER_HIGH; cntNext[i] = ENTER_CNT;
            end else begin
              stateNext[i] = NORMAL;     cntNext[i] = '0;
            end
          end
          ALARM_LOW, ALARM_HIGH: begin
            // Hysteresis: only a run of in-band samples clears; a repeat of the alarm side restarts it.
            if ((cls[i] == IS_LOW && state[i] == ALARM_LOW) ||
                (cls[i] == IS_HIGH && state[i] == ALARM_HIGH)) begin
              cntNext[i] = '0;
            end else if (cls[i] == IS_LOW) begin
              stateNext[i] = ENTER_LOW;  cntNext[i] = ENTER_CNT;
            end else if (cls[i] == IS_HIGH) begin
              stateNext[i] = ENTER_HIGH; cntNext[i] = ENTER_CNT;
            end else if (cntInc[i] == CLEAR_LIM) begin
              stateNext[i] = NORMAL;     cntNext[i] = '0;
            end else begin
              cntNext[i] = cntInc[i][CNT_W-1:0];
            end
          end
          default: begin
            stateNext[i] = NORMAL;
            cntNext[i]   = '0;
          end
        endcase
      end
      enterAlarm[i] = (stateNext[i] == ALARM_LOW || stateNext[i] == ALARM_HIGH) &&
                      (stateNext[i] != state[i]);
      stickyNext[i] = enterAlarm[i] | (stickyAlarm[i] & ~ackMask[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baseReg             <= '0;
      coefReg             <= '0;
      lowTempAbnormality  <= '0;
      highTempAbnormality <= '0;
      stickyAlarm         <= '0;
      anyAlarm            <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= NORMAL;
        cnt[i]   <= '0;
      end
    end else begin
      if (configLoad) begin
        baseReg <= factoryBaseTemp;
        coefReg <= factoryTempCoef;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]               <= stateNext[i];
        cnt[i]                 <= cntNext[i];
        lowTempAbnormality[i]  <= (stateNext[i] == ALARM_LOW);
        highTempAbnormality[i] <= (stateNext[i] == ALARM_HIGH);
      end
      stickyAlarm <= stickyNext;
      anyAlarm    <= |stickyNext;
    end
  end

endmodule

// File: tb/tb_temperature_abnormality_monitor.sv
// Directed bench for temperature_abnormality_monitor with hand-computed expectations.
module tb_temperature_abnormality_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  factoryBaseTemp;
  logic [3:0]  factoryTempCoef;
  logic        configLoad;
  logic        sampleValid;
  logic [19:0] tempSensorValues;
  logic [3:0]  ackMask;
  logic [3:0]  lowTempAbnormality;
  logic [3:0]  highTempAbnormality;
  logic [3:0]  stickyAlarm;
  logic        anyAlarm;

  int nChecks = 0;
  int nFails  = 0;

  temperature_abnormality_monitor #(
    .NUM_CH(4), .TEMP_W(5), .COEF_W(4), .PERSIST_CNT(3), .CLEAR_CNT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .factoryBaseTemp(factoryBaseTemp), .factoryTempCoef(factoryTempCoef),
    .configLoad(configLoad), .sampleValid(sampleValid),
    .tempSensorValues(tempSensorValues), .ackMask(ackMask),
    .lowTempAbnormality(lowTempAbnormality), .highTempAbnormality(highTempAbnormality),
    .stickyAlarm(stickyAlarm), .anyAlarm(anyAlarm)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadCfg(input int base, input int coef);
    factoryBaseTemp = base[4:0];
    factoryTempCoef = coef[3:0];
    configLoad      = 1'b1;
    sampleValid     = 1'b0;
    tick();
    configLoad      = 1'b0;
  endtask

  task automatic sample(input logic [19:0] v);
    tempSensorValues = v;
    sampleValid      = 1'b1;
    tick();
    sampleValid      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; factoryBaseTemp = '0; factoryTempCoef = '0; configLoad = 1'b0;
    sampleValid = 1'b0; tempSensorValues = '0; ackMask = '0;
    #2;
    checkVal("reset_low",    32'(lowTempAbnormality), 0);
    checkVal("reset_high",   32'(highTempAbnormality), 0);
    checkVal("reset_sticky", 32'(stickyAlarm), 0);
    checkVal("reset_any",    32'(anyAlarm), 0);
    tick(); tick();
    rst = 1'b0;
    loadCfg(25, 4);

    // glitch reject on ch1
    sample(pk(25, 20, 25, 25)); checkVal("glitch_s1", 32'(lowTempAbnormality[1]), 0);
    sample(pk(25, 20, 25, 25)); checkVal("glitch_s2", 32'(lowTempAbnormality[1]), 0);
    sample(pk(25, 25, 25, 25)); checkVal("glitch_s3", 32'(lowTempAbnormality[1]), 0);
    sample(pk(25, 20, 25, 25)); checkVal("glitch_s4", 32'(lowTempAbnormality[1]), 0);
    sample(pk(25, 25, 25, 25));

    // persistence on ch0
    sample(pk(30, 25, 25, 25)); checkVal("persist_s1", 32'(highTempAbnormality[0]), 0);
    sample(pk(30, 25, 25, 25)); checkVal("persist_s2", 32'(highTempAbnormality[0]), 0);
    checkVal("persist_s2_sticky", 32'(stickyAlarm), 0);
    sample(pk(30, 25, 25, 25));
    checkVal("persist_s3_high",   32'(highTempAbnormality), 4'b0001);
    checkVal("persist_s3_sticky", 32'(stickyAlarm), 4'b0001);
    checkVal("persist_s3_any",    32'(anyAlarm), 1);

    // hysteresis and ack
    sample(pk(29, 25, 25, 25)); checkVal("hyst_29a", 32'(highTempAbnormality[0]), 1);
    sample(pk(31, 25, 25, 25)); checkVal("hyst_31",  32'(highTempAbnormality[0]), 1);
    sample(pk(29, 25, 25, 25)); checkVal("hyst_29b", 32'(highTempAbnormality[0]), 1);
    sample(pk(29, 25, 25, 25)); checkVal("hyst_29c", 32'(highTempAbnormality[0]), 0);
    checkVal("hyst_sticky_kept", 32'(stickyAlarm), 4'b0001);
    checkVal("hyst_any_kept",    32'(anyAlarm), 1);
    ackMask = 4'b0001; tick(); ackMask = 4'b0000;
    checkVal("ack_sticky", 32'(stickyAlarm), 0);
    checkVal("ack_any",    32'(anyAlarm), 0);

    // ack collides with alarm entry on ch2
    sample(pk(25, 25, 5, 25));
    sample(pk(25, 25, 5, 25));
    ackMask = 4'b0100;
    sample(pk(25, 25, 5, 25));
    ackMask = 4'b0000;
    checkVal("collide_low",    32'(lowTempAbnormality), 4'b0100);
    checkVal("collide_sticky", 32'(stickyAlarm), 4'b0100);
    checkVal("collide_any",    32'(anyAlarm), 1);
    ackMask = 4'b0100; tick(); ackMask = 4'b0000;
    checkVal("collide_ack_after", 32'(stickyAlarm), 0);

    // inclusive band edges (ch2 clears meanwhile)
    for (int k = 0; k < 3; k++) sample(pk(21, 29, 25, 25));
    checkVal("edge_low",    32'(lowTempAbnormality), 0);
    checkVal("edge_high",   32'(highTempAbnormality), 0);
    checkVal("edge_sticky", 32'(stickyAlarm), 0);

    // sampleValid=0 holds pending state on ch3
    sample(pk(25, 25, 25, 5));
    sample(pk(25, 25, 25, 5));
    tempSensorValues = pk(25, 25, 25, 5);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkVal("hold_low3", 32'(lowTempAbnormality[3]), 0);
    end
    sample(pk(25, 25, 25, 5));
    checkVal("hold_resume_low", 32'(lowTempAbnormality), 4'b1000);
    checkVal("hold_sticky",     32'(stickyAlarm), 4'b1000);

    // async reset mid-alarm
    #3 rst = 1'b1;
    #1;
    checkVal("arst_low",    32'(lowTempAbnormality), 0);
    checkVal("arst_high",   32'(highTempAbnormality), 0);
    checkVal("arst_sticky", 32'(stickyAlarm), 0);
    checkVal("arst_any",    32'(anyAlarm), 0);
    tick();
    rst = 1'b0;
    // config is back to 0/0, so band is [0,0]
    for (int k = 0; k < 3; k++) sample(pk(1, 0, 0, 0));
    checkVal("arst_cfg_zero", 32'(highTempAbnormality), 4'b0001);

    // low limit saturates at 0
    loadCfg(2, 4);
    for (int k = 0; k < 3; k++) sample(pk(0, 3, 3, 3));
    checkVal("sat_low",  32'(lowTempAbnormality), 0);
    checkVal("sat_high", 32'(highTempAbnormality), 0);

    // high limit keeps its carry bit (46)
    loadCfg(31, 15);
    for (int k = 0; k < 3; k++) sample(pk(31, 20, 20, 20));
    checkVal("wide_high", 32'(highTempAbnormality), 0);
    checkVal("wide_low",  32'(lowTempAbnormality), 0);

    // sample alongside configLoad uses the old band
    loadCfg(25, 4);
    sample(pk(30, 12, 25, 25));
    sample(pk(30, 12, 25, 25));
    factoryBaseTemp = 5'd10; factoryTempCoef = 4'd4; configLoad = 1'b1;
    sample(pk(30, 12, 25, 25));
    configLoad = 1'b0;
    checkVal("cfgsame_high0", 32'(highTempAbnormality), 4'b0001);
    checkVal("cfgsame_low1",  32'(lowTempAbnormality), 4'b0010);
    // new band [6,14] now applies: ch1=12 is in band and clears
    sample(pk(30, 12, 10, 10));
    sample(pk(30, 12, 10, 10));
    checkVal("cfgnew_low",  32'(lowTempAbnormality), 0);
    checkVal("cfgnew_high", 32'(highTempAbnormality), 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
